// File: rtl/alu_muldiv.sv
// ALU with iterative shift-add multiplier and optional restoring divider.
// Define ALU_MULDIV_DIV_EN to build the divider (DIVU, ctl=4) and its DIV state.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctl,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_MULTU = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_MFHI  = 4'd9;
  localparam logic [3:0] OP_MFLO  = 4'd10;
  localparam logic [3:0] OP_NOR   = 4'd12;
`ifdef ALU_MULDIV_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd4;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] out_q, hi_q, lo_q;
  logic             zero_q, ovf_q, busy_q, done_q;
  // Shared iteration registers: partial product / remainder, multiplier / quotient, and the other operand.
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;

  logic [WIDTH-1:0] sum_w, diff_w, alu_res_d;
  logic             alu_ovf_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;

  assign out      = out_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign cnt_d    = cnt_q + CW'(1);

  always_comb begin
    sum_w     = a + b;
    diff_w    = a - b;
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (ctl)
      OP_AND:  alu_res_d = a & b;
      OP_OR:   alu_res_d = a | b;
      OP_ADD: begin
        alu_res_d = sum_w;
        alu_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_w;
        alu_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  alu_res_d = ~(a | b);
      OP_MFHI: alu_res_d = hi_q;
      OP_MFLO: alu_res_d = lo_q;
      default: alu_res_d = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_d = mul_sum[WIDTH:1];
    mul_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
  end

`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_d, div_lo_d;

  // Restoring step: the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    div_hi_d  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_d  = {acc_lo_q[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (ctl)
              OP_MULTU: begin
                state_q  <= MUL;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                acc_hi_q <= '0;
                acc_lo_q <= b;
                opnd_q   <= a;
              end
`ifdef ALU_MULDIV_DIV_EN
              OP_DIVU: begin
                if (b == '0) begin
                  lo_q   <= '1;
                  hi_q   <= a;
                  done_q <= 1'b1;
                end else begin
                  state_q  <= DIV;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  acc_hi_q <= '0;
                  acc_lo_q <= a;
                  opnd_q   <= b;
                end
              end
`endif
              default: begin
                out_q  <= alu_res_d;
                zero_q <= (alu_res_d == '0);
                ovf_q  <= alu_ovf_d;
                done_q <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc_hi_q <= mul_hi_d;
          acc_lo_q <= mul_lo_d;
          cnt_q    <= cnt_d;
          if (cnt_d == CW'(WIDTH)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            hi_q    <= mul_hi_d;
            lo_q    <= mul_lo_d;
          end
        end
`ifdef ALU_MULDIV_DIV_EN
        DIV: begin
          acc_hi_q <= div_hi_d;
          acc_lo_q <= div_lo_d;
          cnt_q    <= cnt_d;
          if (cnt_d == CW'(WIDTH)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            hi_q    <= div_hi_d;
            lo_q    <= div_lo_d;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized and directed bench for alu_muldiv (WIDTH=32) against an arithmetic reference model.
module tb_alu_muldiv;

`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  ctl;
  logic        start;
  logic [31:0] dut_out, dut_hi, dut_lo;
  logic        dut_zero, dut_ovf, dut_busy, dut_done;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [31:0] m_out, m_hi, m_lo;
  logic        m_ovf;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ctl(ctl), .start(start),
    .out(dut_out), .zero(dut_zero), .overflow(dut_ovf),
    .busy(dut_busy), .done(dut_done), .hi(dut_hi), .lo(dut_lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input bit inject);
    logic [63:0] p;
    longint      s;
    bit          multi;
    int          n_busy;
    int          guard;
    multi = (c == 4'd3) || (DIV_EN && c == 4'd4 && y != 0);
    case (c)
      4'd0:  begin m_out = x & y;  m_ovf = 0; end
      4'd1:  begin m_out = x | y;  m_ovf = 0; end
      4'd2:  begin
        s = longint'($signed(x)) + longint'($signed(y));
        m_out = x + y;
        m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6:  begin
        s = longint'($signed(x)) - longint'($signed(y));
        m_out = x - y;
        m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  begin m_out = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; m_ovf = 0; end
      4'd8:  begin m_out = (x < y) ? 32'd1 : 32'd0; m_ovf = 0; end
      4'd12: begin m_out = ~(x | y); m_ovf = 0; end
      4'd9:  begin m_out = m_hi; m_ovf = 0; end
      4'd10: begin m_out = m_lo; m_ovf = 0; end
      4'd3:  begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd4:  begin
        if (DIV_EN) begin
          if (y == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = x; end
          else begin m_lo = x / y; m_hi = x % y; end
        end else begin
          m_out = 0; m_ovf = 0;
        end
      end
      default: begin m_out = 0; m_ovf = 0; end
    endcase

    ctl = c; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!multi) begin
      check("done_1cyc", dut_done, 1'b1);
      check("busy_1cyc", dut_busy, 1'b0);
    end else begin
      check("busy_start", dut_busy, 1'b1);
      check("done_early", dut_done, 1'b0);
      n_busy = 1;
      guard = 0;
      while (!dut_done && guard < 200) begin
        if (inject && guard == 5) begin
          ctl = 4'd2; a = 32'd5; b = 32'd6; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        if (dut_busy) n_busy++;
        guard++;
      end
      check("done_seen", dut_done, 1'b1);
      check("busy_cycles", n_busy, 32);
      check("busy_end", dut_busy, 1'b0);
    end
    $display("op ctl=%0d a=%h b=%h -> out=%h z=%b ovf=%b hi=%h lo=%h", c, x, y, dut_out, dut_zero, dut_ovf, dut_hi, dut_lo);
    check("out", dut_out, m_out);
    check("zero", dut_zero, (m_out == 0));
    check("ovf", dut_ovf, m_ovf);
    check("hi", dut_hi, m_hi);
    check("lo", dut_lo, m_lo);
    if (multi || c == 4'd4) begin
      @(negedge clk);
      check("done_pulse", dut_done, 1'b0);
    end
  endtask

  initial begin
    bit          done_seen;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = 0; b = 0; ctl = 0;
    m_out = 0; m_hi = 0; m_lo = 0; m_ovf = 0;
    repeat (2) @(negedge clk);
    check("rst_out", dut_out, 32'd0);
    check("rst_zero", dut_zero, 1'b1);
    check("rst_ovf", dut_ovf, 1'b0);
    check("rst_busy", dut_busy, 1'b0);
    check("rst_done", dut_done, 1'b0);
    check("rst_hi", dut_hi, 32'd0);
    check("rst_lo", dut_lo, 32'd0);

    // Start presented in the very first cycle after release.
    rst = 1'b0;
    run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd12, 32'd0, 32'd0, 0);
    run_op(4'd6, 32'h8000_0000, 32'd1, 0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(4'd9, 32'd0, 32'd0, 0);
    run_op(4'd10, 32'd0, 32'd0, 0);
    run_op(4'd4, 32'd100, 32'd7, 1);
    run_op(4'd10, 32'd0, 32'd0, 0);
    run_op(4'd4, 32'd5, 32'd0, 0);
    run_op(4'd9, 32'd0, 32'd0, 0);
    run_op(4'd15, 32'd3, 32'd3, 0);

    // Abort a multiply with reset.
    ctl = 4'd3; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    m_out = 0; m_hi = 0; m_lo = 0; m_ovf = 0;
    check("abort_out", dut_out, 32'd0);
    check("abort_zero", dut_zero, 1'b1);
    check("abort_busy", dut_busy, 1'b0);
    check("abort_hi", dut_hi, 32'd0);
    check("abort_lo", dut_lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dut_done || dut_busy) done_seen = 1;
    end
    check("abort_no_done", done_seen, 1'b0);
    check("abort_hi_hold", dut_hi, 32'd0);
    run_op(4'd2, 32'd1, 32'd1, 0);

    for (int i = 0; i < 50; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = rb;
        default: ;
      endcase
      run_op(rc, ra, rb, (i % 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
